cpu_out_uart: RTL

- Downstream consumer of the accumulator CPU's output port.
- Watches the CPU command bus for OUT (8'h05) and captures the value the CPU latches onto port_out. Buffers captured bytes in a small FIFO and serialises them on a UART TX line (8N1, LSB first).
- Lets programs stream results off-chip without stalling the CPU, which has no backpressure.

---
 rtl/cpu_out_uart.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/cpu_out_uart.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cpu_out_uart                                                    |
// | Purpose  : Captures bytes the accumulator CPU writes with its OUT opcode,  |
// |            buffers them in a small FIFO and sends them on an 8N1 UART line |
// |            (LSB first). The CPU cannot be stalled, so bytes that arrive    |
// |            when the FIFO is full are dropped and flagged.                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
// | Parameters                                                                 |
// |   DEPTH        FIFO entries (power of two, >= 2)                           |
// |   CLKS_PER_BIT clock cycles per UART bit (>= 2)                            |
// |   OUT_OPCODE   command value that marks a port write                       |
// | Ports                                                                      |
// |   clock      in   system clock, posedge                                    |
// |   reset      in   synchronous, active-low                                  |
// |   cmd_in     in   CPU current opcode                                       |
// |   port_data  in   CPU output port value                                    |
// |   ovf_clr    in   clears the overflow flag                                 |
// |   tx         out  UART serial line, idle high, registered                  |
// |   busy       out  FIFO non-empty or transmitter active                     |
// |   fifo_count out  bytes currently buffered                                 |
// |   overflow   out  sticky: a captured byte was dropped                      |
// | Build option                                                               |
// |   CPU_OUT_UART_PARITY_EN  adds an even-parity bit between data and stop    |
// +----------------------------------------------------------------------------+
module cpu_out_uart #(
  parameter int         DEPTH        = 8,
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] OUT_OPCODE   = 8'h05
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [7:0]                   cmd_in,
  input  logic [7:0]                   port_data,
  input  logic                         ovf_clr,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int CLK_W = $clog2(CLKS_PER_BIT);

`ifdef CPU_OUT_UART_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
  } state_t;
`endif

  state_t             state_q;
  logic               out_seen_q;
  logic [7:0]         mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               ovf_q;
  logic               tx_q;
  logic [7:0]         shift_q;
  logic [2:0]         bit_idx_q;
  logic [CLK_W-1:0]   clk_cnt_q;
`ifdef CPU_OUT_UART_PARITY_EN
  logic               par_q;
`endif

  logic w_full;
  logic w_pop;
  logic w_push_ok;
  logic w_drop;
  logic w_bit_end;

  // The CPU drives port_out on the OUT edge, so the byte is valid one cycle
  // later: out_seen_q marks that cycle as a push.
  assign w_full    = (count_q == CNT_W'(DEPTH));
  assign w_pop     = (state_q == S_IDLE) && (count_q != '0);
  // A pop on the same edge frees a slot, so a full FIFO still accepts.
  assign w_push_ok = out_seen_q && (!w_full || w_pop);
  assign w_drop    = out_seen_q && w_full && !w_pop;
  assign w_bit_end = (clk_cnt_q == CLK_W'(CLKS_PER_BIT - 1));

  assign tx         = tx_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign busy       = (count_q != '0) || (state_q != S_IDLE);

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      mem_q[wr_ptr_q] <= port_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_seen_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      out_seen_q <= (cmd_in == OUT_OPCODE);
      if (w_push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (w_push_ok && !w_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!w_push_ok && w_pop) begin
        count_q <= count_q - CNT_W'(1);
      end
      // A new drop takes priority over a clear on the same edge.
      if (w_drop) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Transmit FSM; tx_q is loaded with the level of the state being entered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      tx_q      <= 1'b1;
      shift_q   <= '0;
      bit_idx_q <= '0;
      clk_cnt_q <= '0;
`ifdef CPU_OUT_UART_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (w_pop) begin
            shift_q   <= mem_q[rd_ptr_q];
            clk_cnt_q <= '0;
            tx_q      <= 1'b0;
            state_q   <= S_START;
`ifdef CPU_OUT_UART_PARITY_EN
            par_q     <= ^mem_q[rd_ptr_q];
`endif
          end
        end
        S_START: begin
          if (w_bit_end) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= S_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CLK_W'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            clk_cnt_q <= '0;
            shift_q   <= shift_q >> 1;
            if (bit_idx_q == 3'd7) begin
`ifdef CPU_OUT_UART_PARITY_EN
              tx_q    <= par_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CLK_W'(1);
          end
        end
`ifdef CPU_OUT_UART_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            clk_cnt_q <= '0;
            tx_q      <= 1'b1;
            state_q   <= S_STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + CLK_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            clk_cnt_q <= '0;
            state_q   <= S_IDLE;
          end else begin
            clk_cnt_q <= clk_cnt_q + CLK_W'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
